// File: rtl/dds_dac_sequencer.sv
// dds_dac_sequencer
//   Output-side controller for the DDS board. It debounces the mode button
//   and the filter/FSK switches, and steps the waveform mode index on each
//   button press. It picks one of the eight sample sources and converts
//   signed sources to offset binary. At a fixed sample rate it runs the
//   DAC0832 double-buffered write handshake.
//
// Ports
//   sys_clk, rst            clock (rising edge), async active-high reset
//   btn_mode                raw mode button, press = 1
//   sw_filter, sw_fsk       raw filter-enable and FSK key switches
//   src_sin/saw/squ/tri     unsigned offset-binary samples
//   src_am/fm/fsk           two's-complement samples
//   src_filt                unsigned filtered sine
//   index                   current mode 0..6
//   key                     debounced sw_fsk
//   data                    DAC data bus, held for the whole transaction
//   ILE, CS, WR1, WR2, XFER DAC0832 control (CS/WR1/WR2/XFER active-low)
//   busy                    DAC transaction in progress
//   overrun                 sticky: a sample tick arrived while busy
module dds_dac_sequencer #(
  parameter int unsigned DEB_CYCLES    = 1_000_000,
  parameter int unsigned DAC_PERIOD    = 50,
  parameter int unsigned WR_PULSE      = 4,
  parameter int unsigned BLANK_SAMPLES = 16
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       sw_filter,
  input  logic       sw_fsk,
  input  logic [7:0] src_sin,
  input  logic [7:0] src_saw,
  input  logic [7:0] src_squ,
  input  logic [7:0] src_tri,
  input  logic [7:0] src_am,
  input  logic [7:0] src_fm,
  input  logic [7:0] src_fsk,
  input  logic [7:0] src_filt,
  output logic [2:0] index,
  output logic       key,
  output logic [7:0] data,
  output logic       ILE,
  output logic       CS,
  output logic       WR1,
  output logic       WR2,
  output logic       XFER,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned DW = (DEB_CYCLES > 1)    ? $clog2(DEB_CYCLES)      : 1;
  localparam int unsigned TW = (DAC_PERIOD > 1)    ? $clog2(DAC_PERIOD)      : 1;
  localparam int unsigned PW = (WR_PULSE > 1)      ? $clog2(WR_PULSE)        : 1;
  localparam int unsigned BW = (BLANK_SAMPLES > 0) ? $clog2(BLANK_SAMPLES+1) : 1;

  localparam logic [7:0] MIDSCALE = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LATCH,
    S_HOLD,
    S_XFER,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------
  // Input conditioning: bit 0 = btn_mode, bit 1 = sw_filter, bit 2 = sw_fsk
  // ---------------------------------------------------------------------
  logic [2:0]    sync1, sync2, deb, deb_flip;
  logic [DW-1:0] deb_cnt [3];

  always_comb begin
    deb_flip = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      deb_flip[i] = (sync2[i] != deb[i]) && (deb_cnt[i] == DW'(DEB_CYCLES - 1));
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int unsigned i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= {sw_fsk, sw_filter, btn_mode};
      sync2 <= sync1;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_flip[i]) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Rising edge of the debounced button, taken on the cycle the debouncer
  // flips so no extra edge-detect register is needed.
  logic mode_step;
  assign mode_step = deb_flip[0] & sync2[0];
  assign key       = deb[2];

  // ---------------------------------------------------------------------
  // Sample tick
  // ---------------------------------------------------------------------
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(DAC_PERIOD - 1));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  // ---------------------------------------------------------------------
  // Source select
  // ---------------------------------------------------------------------
  logic [BW-1:0] blank_cnt;
  logic [7:0]    sel_sample;

  always_comb begin
    sel_sample = MIDSCALE;
    case (index)
      3'd0:    sel_sample = deb[1] ? src_filt : src_sin;
      3'd1:    sel_sample = src_saw;
      3'd2:    sel_sample = src_squ;
      3'd3:    sel_sample = src_tri;
      3'd4:    sel_sample = src_am  + MIDSCALE;
      3'd5:    sel_sample = src_fm  + MIDSCALE;
      3'd6:    sel_sample = src_fsk + MIDSCALE;
      default: sel_sample = MIDSCALE;
    endcase
    if (blank_cnt != '0) sel_sample = MIDSCALE;
  end

  // ---------------------------------------------------------------------
  // DAC handshake FSM
  // ---------------------------------------------------------------------
  state_t        state, state_nxt;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic          capture;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pcnt  <= '0;
    end else begin
      state <= state_nxt;
      pcnt  <= pcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick) begin
          capture   = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        pcnt_nxt  = '0;
        state_nxt = S_LATCH;
      end
      S_LATCH: begin
        if (pcnt == PW'(WR_PULSE - 1)) begin
          pcnt_nxt  = '0;
          state_nxt = S_HOLD;
        end else begin
          pcnt_nxt  = pcnt + PW'(1);
        end
      end
      S_HOLD: begin
        pcnt_nxt  = '0;
        state_nxt = S_XFER;
      end
      S_XFER: begin
        if (pcnt == PW'(WR_PULSE - 1)) begin
          pcnt_nxt  = '0;
          state_nxt = S_DONE;
        end else begin
          pcnt_nxt  = pcnt + PW'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes decode straight from the state register, so an async reset
  // releases every strobe in the same instant the state returns to IDLE.
  always_comb begin
    ILE  = 1'b1;
    CS   = 1'b1;
    WR1  = 1'b1;
    WR2  = 1'b1;
    XFER = 1'b1;
    busy = (state != S_IDLE);
    case (state)
      S_SETUP: CS = 1'b0;
      S_LATCH: begin
        CS  = 1'b0;
        WR1 = 1'b0;
      end
      S_HOLD:  CS = 1'b0;
      S_XFER: begin
        CS   = 1'b0;
        WR2  = 1'b0;
        XFER = 1'b0;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Mode index, blanking, captured data, overrun
  // ---------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      index     <= '0;
      blank_cnt <= '0;
      data      <= MIDSCALE;
      overrun   <= 1'b0;
    end else begin
      if (capture) data <= sel_sample;

      // A fresh mode change reloads blanking even if a capture in the same
      // cycle would otherwise consume one blank slot.
      if (mode_step) begin
        index     <= (index == 3'd6) ? 3'd0 : index + 3'd1;
        blank_cnt <= BW'(BLANK_SAMPLES);
      end else if (capture && (blank_cnt != '0)) begin
        blank_cnt <= blank_cnt - BW'(1);
      end

      if (tick && (state != S_IDLE)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dds_dac_sequencer.sv
module tb_dds_dac_sequencer;

  localparam int DEB = 8;
  localparam int P   = 16;
  localparam int WR  = 2;
  localparam int BL  = 2;

  logic       clk = 1'b0;
  logic       rst, rst_b;
  logic       btn_mode, sw_filter, sw_fsk;
  logic [7:0] src_sin, src_saw, src_squ, src_tri, src_am, src_fm, src_fsk, src_filt;

  logic [2:0] index, index_b;
  logic       key, key_b;
  logic [7:0] data, data_b;
  logic       ILE, CS, WR1, WR2, XFER, busy, overrun;
  logic       ILE_b, CS_b, WR1_b, WR2_b, XFER_b, busy_b, overrun_b;

  always #5 clk = ~clk;

  dds_dac_sequencer #(
    .DEB_CYCLES(DEB), .DAC_PERIOD(P), .WR_PULSE(WR), .BLANK_SAMPLES(BL)
  ) dut (
    .sys_clk(clk), .rst(rst), .btn_mode(btn_mode), .sw_filter(sw_filter), .sw_fsk(sw_fsk),
    .src_sin(src_sin), .src_saw(src_saw), .src_squ(src_squ), .src_tri(src_tri),
    .src_am(src_am), .src_fm(src_fm), .src_fsk(src_fsk), .src_filt(src_filt),
    .index(index), .key(key), .data(data), .ILE(ILE), .CS(CS), .WR1(WR1), .WR2(WR2),
    .XFER(XFER), .busy(busy), .overrun(overrun)
  );

  // Sample period shorter than one transaction: must flag overrun.
  dds_dac_sequencer #(
    .DEB_CYCLES(DEB), .DAC_PERIOD(6), .WR_PULSE(WR), .BLANK_SAMPLES(BL)
  ) dut_b (
    .sys_clk(clk), .rst(rst_b), .btn_mode(btn_mode), .sw_filter(sw_filter), .sw_fsk(sw_fsk),
    .src_sin(src_sin), .src_saw(src_saw), .src_squ(src_squ), .src_tri(src_tri),
    .src_am(src_am), .src_fm(src_fm), .src_fsk(src_fsk), .src_filt(src_filt),
    .index(index_b), .key(key_b), .data(data_b), .ILE(ILE_b), .CS(CS_b), .WR1(WR1_b),
    .WR2(WR2_b), .XFER(XFER_b), .busy(busy_b), .overrun(overrun_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: values seen after each rising edge.
  int m_s1[3], m_s2[3], m_deb[3], m_run[3];
  int m_idx, m_blank, m_tcnt, m_k, m_data, m_ovr;

  // Bookkeeping on observed behaviour
  int   n_busy, n_wr1, n_xfer, step_pos;
  int   caps[$];
  logic prev_busy;
  logic [2:0] prev_idx;

  function automatic int src_sel(int idx, bit filt);
    case (idx)
      0:       return filt ? int'(src_filt) : int'(src_sin);
      1:       return int'(src_saw);
      2:       return int'(src_squ);
      3:       return int'(src_tri);
      4:       return (int'(src_am)  + 128) % 256;
      5:       return (int'(src_fm)  + 128) % 256;
      6:       return (int'(src_fsk) + 128) % 256;
      default: return 128;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_run[i] = 0;
    end
    m_idx = 0; m_blank = 0; m_tcnt = 0; m_k = 0; m_data = 128; m_ovr = 0;
  endtask

  // Phase k counts cycles since the accepted tick: 1 setup, 2..WR+1 latch,
  // WR+2 hold, WR+3..2WR+2 transfer, 2WR+3 done, 0 idle.
  task automatic model_step();
    int  raw[3], nd[3], nr[3];
    bit  tick, cap, step;
    raw[0] = int'(btn_mode); raw[1] = int'(sw_filter); raw[2] = int'(sw_fsk);
    tick = (m_tcnt == P - 1);
    cap  = (m_k == 0) && tick;
    for (int i = 0; i < 3; i++) begin
      nd[i] = m_deb[i];
      nr[i] = 0;
      if (m_s2[i] != m_deb[i]) begin
        nr[i] = m_run[i] + 1;
        if (nr[i] == DEB) begin
          nd[i] = m_s2[i];
          nr[i] = 0;
        end
      end
    end
    step = (m_deb[0] == 0) && (nd[0] == 1);
    if (cap) m_data = (m_blank != 0) ? 128 : src_sel(m_idx, m_deb[1] != 0);
    if (m_k != 0 && tick) m_ovr = 1;
    if (cap) m_k = 1;
    else if (m_k != 0) m_k = (m_k == 2*WR + 3) ? 0 : m_k + 1;
    if (step) m_blank = BL;
    else if (cap && m_blank > 0) m_blank--;
    if (step) m_idx = (m_idx + 1) % 7;
    m_tcnt = tick ? 0 : m_tcnt + 1;
    for (int i = 0; i < 3; i++) begin
      m_deb[i] = nd[i]; m_run[i] = nr[i]; m_s2[i] = m_s1[i]; m_s1[i] = raw[i];
    end
  endtask

  task automatic run_cycle();
    logic [7:0] e;
    model_step();
    @(posedge clk);
    @(negedge clk);
    e[7] = (m_deb[2] != 0);
    e[6] = 1'b1;
    e[5] = !(m_k >= 1 && m_k <= 2*WR + 2);
    e[4] = !(m_k >= 2 && m_k <= WR + 1);
    e[3] = !(m_k >= WR + 3 && m_k <= 2*WR + 2);
    e[2] = e[3];
    e[1] = (m_k != 0);
    e[0] = (m_ovr != 0);
    check_eq("index", 32'(index), m_idx);
    check_eq("data",  32'(data),  m_data);
    check_eq("ctrl key/ILE/CS/WR1/WR2/XFER/busy/ovr",
             32'({key, ILE, CS, WR1, WR2, XFER, busy, overrun}), 32'(e));
    if (busy) n_busy++;
    if (!WR1) n_wr1++;
    if (!XFER) n_xfer++;
    if (busy && !prev_busy) caps.push_back(int'(data));
    prev_busy = busy;
    if (index != prev_idx) begin
      step_pos = caps.size();
      prev_idx = index;
    end
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn_mode = 1'b0; sw_filter = 1'b0; sw_fsk = 1'b0;
    model_reset();
    @(negedge clk);
    check_eq("rst_index", 32'(index), 0);
    check_eq("rst_data",  32'(data),  32'h80);
    check_eq("rst_ctrl",  32'({key, ILE, CS, WR1, WR2, XFER, busy, overrun}), 32'b0111_1100);
    rst = 1'b0;
    prev_busy = 1'b0;
    prev_idx  = '0;
  endtask

  task automatic press(input int hi, input int lo);
    btn_mode = 1'b1; run_n(hi);
    btn_mode = 1'b0; run_n(lo);
  endtask

  initial begin
    bit found;
    rst = 1'b1; rst_b = 1'b1;
    btn_mode = 1'b0; sw_filter = 1'b0; sw_fsk = 1'b0;
    src_sin = 8'h3C; src_saw = 8'h5A; src_squ = 8'hF0; src_tri = 8'h11;
    src_am = 8'h00; src_fm = 8'h00; src_fsk = 8'h00; src_filt = 8'hA5;
    step_pos = 0;

    // Scenario 1: four clean transactions of src_sin
    do_reset();
    rst_b = 1'b0;
    check_eq("b_rst_overrun", 32'(overrun_b), 0);
    n_busy = 0; n_wr1 = 0; n_xfer = 0; caps.delete();
    run_n(74);
    check_eq("s1_captures", caps.size(), 4);
    foreach (caps[i]) check_eq("s1_cap_data", caps[i], 32'h3C);
    check_eq("s1_busy_cycles", n_busy, 28);
    check_eq("s1_wr1_low",     n_wr1,  8);
    check_eq("s1_xfer_low",    n_xfer, 8);
    check_eq("s1_overrun",     32'(overrun), 0);

    // Scenario 2: bouncing press gives one step, then two blanked samples
    caps.delete(); step_pos = 0;
    btn_mode = 1'b1; run_n(3);
    btn_mode = 1'b0; run_n(3);
    btn_mode = 1'b1; run_n(3);
    run_n(20);
    btn_mode = 1'b0; run_n(20);
    check_eq("s2_index", 32'(index), 1);
    for (int i = 0; i < 100 && caps.size() < step_pos + 3; i++) run_cycle();
    check_eq("s2_caps_avail", 32'(caps.size() >= step_pos + 3), 1);
    if (caps.size() >= step_pos + 3) begin
      check_eq("s2_blank0", caps[step_pos],     32'h80);
      check_eq("s2_blank1", caps[step_pos + 1], 32'h80);
      check_eq("s2_saw",    caps[step_pos + 2], 32'h5A);
    end

    // Scenario 3: seven presses walk 1..6 and wrap to 0
    do_reset();
    for (int p = 0; p < 7; p++) begin
      press(12, 12);
      check_eq("s3_index", 32'(index), (p + 1) % 7);
    end

    // Scenario 4: AM offset conversion at the signed extremes
    do_reset();
    src_am = 8'h7F;
    for (int p = 0; p < 4; p++) press(12, 12);
    check_eq("s4_index", 32'(index), 4);
    run_n(64);
    check_eq("s4_am_7f", 32'(data), 32'hFF);
    src_am = 8'h80;
    run_n(20);
    check_eq("s4_am_80", 32'(data), 32'h00);

    // Scenario 5: filter switch long enough vs. too short
    do_reset();
    sw_filter = 1'b1; run_n(10);
    sw_filter = 1'b0; run_n(14);
    check_eq("s5_filt", 32'(data), 32'hA5);
    run_n(40);
    sw_filter = 1'b1; run_n(5);
    sw_filter = 1'b0; run_n(40);
    check_eq("s5_sin", 32'(data), 32'h3C);

    // Random stimulus against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) btn_mode  = ~btn_mode;
      if ($urandom_range(0, 19) == 0) sw_filter = ~sw_filter;
      if ($urandom_range(0, 19) == 0) sw_fsk    = ~sw_fsk;
      src_sin  = 8'($urandom); src_saw = 8'($urandom); src_squ = 8'($urandom);
      src_tri  = 8'($urandom); src_am  = 8'($urandom); src_fm  = 8'($urandom);
      src_fsk  = 8'($urandom); src_filt = 8'($urandom);
      run_cycle();
    end

    // Scenario 6: overrun on the short-period instance, async reset in LATCH
    check_eq("b_overrun", 32'(overrun_b), 1);
    src_sin = 8'h3C;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_k == 2) begin
        found = 1'b1;
        break;
      end
      run_cycle();
    end
    check_eq("s6_latch_reached", 32'(found), 1);
    if (found) begin
      check_eq("s6_wr1_low_before", 32'(WR1), 0);
      rst = 1'b1;
      #1;
      check_eq("s6_rst_wr1",  32'(WR1),  1);
      check_eq("s6_rst_cs",   32'(CS),   1);
      check_eq("s6_rst_data", 32'(data), 32'h80);
      check_eq("s6_rst_xfer", 32'({WR2, XFER, busy}), 32'b110);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      prev_busy = 1'b0;
      prev_idx  = '0;
      run_n(20);
    end
    check_eq("b_overrun_sticky", 32'(overrun_b), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
